// File: rtl/tow_pkg.sv
// Shared state encodings and elaboration helpers for the Tug-of-War round sequencer.
package tow_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_ARMED   = 3'd1,
    ST_QUAL    = 3'd2,
    ST_MOVE    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_WIN     = 3'd5
  } tow_state_e;

  function automatic int tow_clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

  function automatic int tow_center(input int leds);
    return (leds - 1) / 2;
  endfunction

endpackage

// File: rtl/tow_sync.sv
// Parameterized-width two-flop synchronizer, asynchronous active-high reset to zero.
module tow_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // two-stage capture of the asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/tow_referee.sv
// Tug-of-War round sequencer: qualifies arbiter decisions, steps the rope, declares the winner.
// Optional macro TOW_TIE_RECENTER_EN: a qualified tie recentres the rope instead of leaving it.
module tow_referee
  import tow_pkg::*;
#(
  parameter int LEDS     = 9,
  parameter int DEBOUNCE = 4,
  parameter int LOCKOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       tie,
  input  logic                       right,
  output logic                       clr,
  output logic [tow_clog2(LEDS)-1:0] pos,
  output logic [LEDS-1:0]            leds,
  output logic                       win_l,
  output logic                       win_r,
  output logic                       tie_flag,
  output logic                       busy
);

  localparam int PW      = tow_clog2(LEDS);
  localparam int CNT_MAX = (DEBOUNCE > LOCKOUT) ? DEBOUNCE : LOCKOUT;
  localparam int CW      = tow_clog2(CNT_MAX) + 1;

  localparam logic [PW-1:0]   CENTER_P = PW'(tow_center(LEDS));
  localparam logic [PW-1:0]   LAST_P   = PW'(LEDS - 1);
  localparam logic [CW-1:0]   DEB_LIM  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]   LOCK_LIM = CW'(LOCKOUT - 1);
  localparam logic [LEDS-1:0] LED_BASE = LEDS'(1);

  logic       push_s, tie_s, right_s;
  tow_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d, move_pos_s;
  logic tie_q, tie_d, right_q, right_d;
  logic win_l_q, win_l_d, win_r_q, win_r_d;

  tow_sync #(.WIDTH(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({push, tie, right}),
    .q   ({push_s, tie_s, right_s})
  );

  // round state, counters, captured decision and sticky winner flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      pos_q   <= CENTER_P;
      tie_q   <= 1'b0;
      right_q <= 1'b0;
      win_l_q <= 1'b0;
      win_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      tie_q   <= tie_d;
      right_q <= right_d;
      win_l_q <= win_l_d;
      win_r_q <= win_r_d;
    end
  end

  // rope target for the MOVE cycle; a tie takes priority over the race winner
  always_comb begin
    move_pos_s = pos_q;
    if (tie_q) begin
`ifdef TOW_TIE_RECENTER_EN
      move_pos_s = CENTER_P;
`else
      move_pos_s = pos_q;
`endif
    end else if (right_q) begin
      move_pos_s = pos_q + PW'(1);
    end else begin
      move_pos_s = pos_q - PW'(1);
    end
  end

  // next-state logic for the round sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    tie_d   = tie_q;
    right_d = right_q;
    win_l_d = win_l_q;
    win_r_d = win_r_q;
    case (state_q)
      ST_CLEAR: begin
        state_d = ST_ARMED;
        cnt_d   = '0;
      end
      ST_ARMED: begin
        if (push_s) begin
          state_d = ST_QUAL;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_QUAL: begin
        if (!push_s) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LIM) begin
          state_d = ST_MOVE;
          cnt_d   = '0;
          tie_d   = tie_s;
          right_d = right_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_MOVE: begin
        pos_d = move_pos_s;
        cnt_d = '0;
        if (move_pos_s == LAST_P) begin
          win_r_d = 1'b1;
          state_d = ST_WIN;
        end else if (move_pos_s == PW'(0)) begin
          win_l_d = 1'b1;
          state_d = ST_WIN;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // arbiter stays latched so the losing button cannot score until a quiet lockout
        if (push_s) begin
          cnt_d = '0;
        end else if (cnt_q >= LOCK_LIM) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WIN: begin
        state_d = ST_WIN;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr      = (state_q == ST_CLEAR) || (state_q == ST_WIN);
  assign busy     = (state_q != ST_ARMED);
  assign tie_flag = (state_q == ST_MOVE) && tie_q;
  assign pos      = pos_q;
  assign leds     = LED_BASE << pos_q;
  assign win_l    = win_l_q;
  assign win_r    = win_r_q;

endmodule

// File: tb/tb_tow_referee.sv
// Scoreboard bench for tow_referee; define TOW_TIE_RECENTER_EN for both RTL and bench to
// exercise the tie-recentre variant.
`timescale 1ns/1ps
module tb_tow_referee;

  localparam int LEDS     = 9;
  localparam int DEBOUNCE = 4;
  localparam int LOCKOUT  = 16;
  localparam int CENTER   = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic push  = 1'b0;
  logic tie   = 1'b0;
  logic right = 1'b0;
  logic clr, win_l, win_r, tie_flag, busy;
  logic [3:0] pos;
  logic [LEDS-1:0] leds;

  typedef struct {
    logic [3:0] pos;
    logic       tie;
    logic       wl;
    logic       wr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int model_pos = CENTER;

  logic [3:0]      obs_pos;
  logic [LEDS-1:0] obs_leds;
  logic [LEDS-1:0] exp_leds;
  logic [LEDS-1:0] led_one = 9'd1;
  logic obs_wl, obs_wr, obs_clr_hold, obs_after_clr, obs_after_busy;
  int obs_k, obs_ties, obs_rearm;

  tow_referee #(.LEDS(LEDS), .DEBOUNCE(DEBOUNCE), .LOCKOUT(LOCKOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .tie      (tie),
    .right    (right),
    .clr      (clr),
    .pos      (pos),
    .leds     (leds),
    .win_l    (win_l),
    .win_r    (win_r),
    .tie_flag (tie_flag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1; push = 1'b0; tie = 1'b0; right = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_pos = CENTER;
    sb.delete();
  endtask

  // one full round: predict outcome, hold buttons, release, then wait for the re-arm pulse
  task automatic drive_round(input logic t, input logic r, input int hold, input int release_wait);
    exp_t e;
    int   start;
    e.tie = t;
    if (t) begin
`ifdef TOW_TIE_RECENTER_EN
      e.pos = 4'(CENTER);
`else
      e.pos = 4'(model_pos);
`endif
    end else if (r) begin
      e.pos = 4'(model_pos + 1);
    end else begin
      e.pos = 4'(model_pos - 1);
    end
    e.wl = (e.pos == 4'd0);
    e.wr = (e.pos == 4'(LEDS - 1));
    model_pos = int'(e.pos);
    sb.push_back(e);
    start = int'(pos);
    obs_k = 0; obs_ties = 0; obs_clr_hold = 1'b0;
    @(negedge clk);
    push = 1'b1; tie = t; right = r;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (tie_flag) obs_ties++;
      if (obs_k == 0 && (tie_flag || int'(pos) != start)) obs_k = k;
      if (clr) obs_clr_hold = 1'b1;
    end
    obs_pos = pos; obs_leds = leds; obs_wl = win_l; obs_wr = win_r;
    push = 1'b0; tie = 1'b0; right = 1'b0;
    obs_rearm = -1;
    for (int j = 1; j <= release_wait; j++) begin
      @(negedge clk);
      if (clr) begin
        obs_rearm = j;
        break;
      end
    end
    @(negedge clk);
    obs_after_clr = clr; obs_after_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (clr !== 1'b1) begin errors++; $display("FAIL reset_clr: got %b expected 1", clr); end
    checks++; if (pos !== 4'd4) begin errors++; $display("FAIL reset_pos: got %0d expected 4", pos); end
    checks++; if (leds !== 9'b000010000) begin errors++; $display("FAIL reset_leds: got %b expected 000010000", leds); end
    checks++; if (win_l !== 1'b0 || win_r !== 1'b0) begin errors++; $display("FAIL reset_win: got %b%b expected 00", win_l, win_r); end
    checks++; if (busy !== 1'b1 || tie_flag !== 1'b0) begin errors++; $display("FAIL reset_busy_tie: got %b%b expected 10", busy, tie_flag); end
    rst = 1'b0;
    #1;
    checks++; if (clr !== 1'b1) begin errors++; $display("FAIL reset_clear_cycle: got %b expected 1", clr); end
    @(negedge clk);
    checks++; if (clr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_armed: clr/busy got %b%b expected 00", clr, busy); end
    model_pos = CENTER;
  endtask

  task automatic test_right();
    exp_t e;
    drive_round(1'b0, 1'b1, 10, 40);
    e = sb.pop_front();
    exp_leds = led_one << e.pos;
    checks++; if (obs_pos !== e.pos) begin errors++; $display("FAIL right_pos: got %0d expected %0d", obs_pos, e.pos); end
    checks++; if (obs_leds !== exp_leds) begin errors++; $display("FAIL right_leds: got %b expected %b", obs_leds, exp_leds); end
    checks++; if (obs_k !== 3 + DEBOUNCE) begin errors++; $display("FAIL right_latency: got %0d expected %0d", obs_k, 3 + DEBOUNCE); end
    checks++; if (obs_clr_hold !== 1'b0) begin errors++; $display("FAIL right_no_clr_hold: got %b expected 0", obs_clr_hold); end
    checks++; if (obs_rearm !== 2 + LOCKOUT) begin errors++; $display("FAIL right_rearm: got %0d expected %0d", obs_rearm, 2 + LOCKOUT); end
    checks++; if (obs_after_clr !== 1'b0 || obs_after_busy !== 1'b0) begin errors++; $display("FAIL right_pulse: clr/busy got %b%b expected 00", obs_after_clr, obs_after_busy); end
  endtask

  task automatic test_glitch();
    logic saw_clr, saw_busy, saw_tie;
    saw_clr = 1'b0; saw_busy = 1'b0; saw_tie = 1'b0;
    @(negedge clk);
    push = 1'b1; right = 1'b1;
    repeat (2) @(negedge clk);
    push = 1'b0; right = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (clr) saw_clr = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (tie_flag) saw_tie = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_qual: got %b expected 1", saw_busy); end
    checks++; if (pos !== 4'(model_pos)) begin errors++; $display("FAIL glitch_pos: got %0d expected %0d", pos, model_pos); end
    checks++; if (saw_clr !== 1'b0 || saw_tie !== 1'b0) begin errors++; $display("FAIL glitch_quiet: clr/tie got %b%b expected 00", saw_clr, saw_tie); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_armed: got %b expected 0", busy); end
  endtask

  task automatic test_tie();
    exp_t e;
    drive_round(1'b0, 1'b1, 10, 40);
    e = sb.pop_front();
    checks++; if (obs_pos !== e.pos) begin errors++; $display("FAIL tie_pre_pos: got %0d expected %0d", obs_pos, e.pos); end
    drive_round(1'b1, 1'b1, 10, 40);
    e = sb.pop_front();
    checks++; if (obs_pos !== e.pos) begin errors++; $display("FAIL tie_pos: got %0d expected %0d", obs_pos, e.pos); end
    checks++; if (obs_ties !== 1) begin errors++; $display("FAIL tie_flag_count: got %0d expected 1", obs_ties); end
    checks++; if (obs_k !== 2 + DEBOUNCE) begin errors++; $display("FAIL tie_latency: got %0d expected %0d", obs_k, 2 + DEBOUNCE); end
    checks++; if (obs_rearm !== 2 + LOCKOUT) begin errors++; $display("FAIL tie_rearm: got %0d expected %0d", obs_rearm, 2 + LOCKOUT); end
  endtask

  task automatic test_held();
    exp_t e;
    drive_round(1'b0, 1'b0, 40, 40);
    e = sb.pop_front();
    checks++; if (obs_pos !== e.pos) begin errors++; $display("FAIL held_pos: got %0d expected %0d", obs_pos, e.pos); end
    checks++; if (obs_clr_hold !== 1'b0) begin errors++; $display("FAIL held_no_rearm: got %b expected 0", obs_clr_hold); end
    checks++; if (obs_rearm !== 2 + LOCKOUT) begin errors++; $display("FAIL held_rearm: got %0d expected %0d", obs_rearm, 2 + LOCKOUT); end
  endtask

  task automatic test_left_win();
    exp_t e;
    logic saw_move;
    while (model_pos > 0) begin
      drive_round(1'b0, 1'b0, 10, 40);
      e = sb.pop_front();
      checks++; if (obs_pos !== e.pos) begin errors++; $display("FAIL left_pos: got %0d expected %0d", obs_pos, e.pos); end
      checks++; if (obs_wl !== e.wl || obs_wr !== e.wr) begin errors++; $display("FAIL left_win_flags: got %b%b expected %b%b", obs_wl, obs_wr, e.wl, e.wr); end
      if (!e.wl) begin
        checks++; if (obs_rearm !== 2 + LOCKOUT) begin errors++; $display("FAIL left_rearm: got %0d expected %0d", obs_rearm, 2 + LOCKOUT); end
      end else begin
        checks++; if (obs_rearm !== 1 || obs_after_clr !== 1'b1) begin errors++; $display("FAIL left_clr_stuck: rearm %0d clr %b expected 1 1", obs_rearm, obs_after_clr); end
      end
    end
    saw_move = 1'b0;
    @(negedge clk);
    push = 1'b1; right = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pos !== 4'd0 || tie_flag || !clr) saw_move = 1'b1;
    end
    push = 1'b0; right = 1'b0;
    checks++; if (saw_move !== 1'b0) begin errors++; $display("FAIL left_frozen: got %b expected 0", saw_move); end
    checks++; if (win_l !== 1'b1 || win_r !== 1'b0) begin errors++; $display("FAIL left_sticky: got %b%b expected 10", win_l, win_r); end
  endtask

  task automatic test_rst_mid_qual();
    exp_t e;
    apply_reset();
    drive_round(1'b0, 1'b1, 10, 40);
    e = sb.pop_front();
    checks++; if (obs_pos !== e.pos) begin errors++; $display("FAIL midq_pre_pos: got %0d expected %0d", obs_pos, e.pos); end
    @(negedge clk);
    push = 1'b1; right = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midq_in_qual: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (pos !== 4'd4 || clr !== 1'b1) begin errors++; $display("FAIL midq_reset: pos %0d clr %b expected 4 1", pos, clr); end
    push = 1'b0; right = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_pos = CENTER;
    checks++; if (busy !== 1'b0 || pos !== 4'd4) begin errors++; $display("FAIL midq_rearm: busy %b pos %0d expected 0 4", busy, pos); end
  endtask

  task automatic test_right_win();
    exp_t e;
    while (model_pos < LEDS - 1) begin
      drive_round(1'b0, 1'b1, 10, 40);
      e = sb.pop_front();
      exp_leds = led_one << e.pos;
      checks++; if (obs_pos !== e.pos || obs_leds !== exp_leds) begin errors++; $display("FAIL rwin_pos: got %0d/%b expected %0d/%b", obs_pos, obs_leds, e.pos, exp_leds); end
      checks++; if (obs_wl !== e.wl || obs_wr !== e.wr) begin errors++; $display("FAIL rwin_flags: got %b%b expected %b%b", obs_wl, obs_wr, e.wl, e.wr); end
    end
    repeat (5) @(negedge clk);
    checks++; if (clr !== 1'b1 || busy !== 1'b1 || pos !== 4'd8) begin errors++; $display("FAIL rwin_hold: clr %b busy %b pos %0d expected 1 1 8", clr, busy, pos); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_right();
    test_glitch();
    test_tie();
    test_held();
    test_left_win();
    test_rst_mid_qual();
    test_right_win();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
